// File: rtl/linear_proj_pkg.sv
// Shared sizing constants and the loader FSM state type for the linear projection datapath.
package linear_proj_pkg;

  localparam int unsigned WIDTH_A        = 8;
  localparam int unsigned CHUNK_SIZE     = 4;
  localparam int unsigned NUM_CORES_A    = 1;
  localparam int unsigned DATA_WIDTH_A   = WIDTH_A * CHUNK_SIZE * NUM_CORES_A;
  localparam int unsigned NUM_A_ELEMENTS = 8;
  localparam int unsigned ADDR_WIDTH_A   = 4;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_FLUSH,
    LD_DONE
  } loader_state_t;

endpackage

// File: rtl/in_mat_stream_loader.sv
// Streams matrix A words in over valid/ready and writes them as even/odd pairs through two
// write ports (even address on port A, odd on port B). An odd word count ends with a port-A-only
// tail write. Optional macro IN_MAT_LOADER_STATS_EN adds the out_load_cycles counter output.
module in_mat_stream_loader
  import linear_proj_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_A,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_A,
  parameter int unsigned NUM_WORDS  = NUM_A_ELEMENTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  in_mat_ena,
  output logic                  in_mat_wea,
  output logic [ADDR_WIDTH-1:0] in_mat_wr_addra,
  output logic [DATA_WIDTH-1:0] in_mat_dina,
  output logic                  in_mat_enb,
  output logic                  in_mat_web,
  output logic [ADDR_WIDTH-1:0] in_mat_wr_addrb,
  output logic [DATA_WIDTH-1:0] in_mat_dinb,
  output logic                  out_busy,
  output logic                  out_done
`ifdef IN_MAT_LOADER_STATS_EN
  ,
  output logic [31:0]           out_load_cycles
`endif
);

  // Wide enough to hold NUM_WORDS itself, so the counter never wraps within a load.
  localparam int unsigned CntW = $clog2(NUM_WORDS + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_WORDS - 1);

  loader_state_t         state_q;
  logic [CntW-1:0]       wcnt_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  s_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ena_q;
  logic                  enb_q;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic [ADDR_WIDTH-1:0] addrb_q;
  logic [DATA_WIDTH-1:0] dina_q;
  logic [DATA_WIDTH-1:0] dinb_q;

  logic                  handshake;
  logic [CntW-1:0]       wcnt_prev;

  assign handshake = s_valid & s_ready_q & (state_q == LD_LOAD);
  assign wcnt_prev = wcnt_q - CntW'(1);

  // Single FSM: sequencing, word counter, even-word holding register and registered write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LD_IDLE;
      wcnt_q    <= '0;
      hold_q    <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ena_q     <= 1'b0;
      enb_q     <= 1'b0;
      addra_q   <= '0;
      addrb_q   <= '0;
      dina_q    <= '0;
      dinb_q    <= '0;
    end else begin
      // Enables and done are pulses; addresses and data hold between writes.
      ena_q  <= 1'b0;
      enb_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        LD_IDLE: begin
          if (in_start) begin
            wcnt_q    <= '0;
            state_q   <= LD_LOAD;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (handshake) begin
            wcnt_q <= wcnt_q + CntW'(1);
            if (!wcnt_q[0]) begin
              hold_q <= s_data;
              // Odd word count: the last word has no partner, write it alone on port A.
              if (wcnt_q == LastIdx) begin
                ena_q   <= 1'b1;
                addra_q <= ADDR_WIDTH'(wcnt_q);
                dina_q  <= s_data;
              end
            end else begin
              ena_q   <= 1'b1;
              enb_q   <= 1'b1;
              addra_q <= ADDR_WIDTH'(wcnt_prev);
              dina_q  <= hold_q;
              addrb_q <= ADDR_WIDTH'(wcnt_q);
              dinb_q  <= s_data;
            end
            if (wcnt_q == LastIdx) begin
              state_q   <= LD_FLUSH;
              s_ready_q <= 1'b0;
            end
          end
        end
        LD_FLUSH: begin
          state_q <= LD_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        LD_DONE: begin
          state_q <= LD_IDLE;
        end
        default: begin
          state_q <= LD_IDLE;
        end
      endcase
    end
  end

  assign s_ready         = s_ready_q;
  assign in_mat_ena      = ena_q;
  assign in_mat_wea      = ena_q;
  assign in_mat_wr_addra = addra_q;
  assign in_mat_dina     = dina_q;
  assign in_mat_enb      = enb_q;
  assign in_mat_web      = enb_q;
  assign in_mat_wr_addrb = addrb_q;
  assign in_mat_dinb     = dinb_q;
  assign out_busy        = busy_q;
  assign out_done        = done_q;

`ifdef IN_MAT_LOADER_STATS_EN
  logic [31:0] cycles_q;

  // Saturating count of LOAD..DONE cycles; cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if (state_q == LD_IDLE) begin
      if (in_start) begin
        cycles_q <= '0;
      end
    end else if (cycles_q != '1) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign out_load_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_in_mat_stream_loader.sv
// Randomized self-checking bench for in_mat_stream_loader. Three instances (8, 7 and 1 words)
// share one stimulus stream; each is checked cycle by cycle against a transaction-level model,
// and the written memory image is compared with the accepted words at every completion.
module tb_in_mat_stream_loader;
  import linear_proj_pkg::*;

  localparam int unsigned DW = DATA_WIDTH_A;
  localparam int unsigned AW = ADDR_WIDTH_A;

  typedef struct packed {
    int unsigned       phase;  // 0 idle, 1 accepting, 2 final write visible, 3 done visible
    int unsigned       cnt;
    logic [DW-1:0]     held;
    logic              ready;
    logic              ena;
    logic              enb;
    logic              busy;
    logic              done;
    logic [AW-1:0]     addra;
    logic [AW-1:0]     addrb;
    logic [DW-1:0]     dina;
    logic [DW-1:0]     dinb;
    logic [31:0]       cycles;
    logic [7:0][DW-1:0] words;
  } model_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_start;
  logic          s_valid;
  logic [DW-1:0] s_data;

  int n_checks = 0;
  int n_errors = 0;

  model_t m8, m7, m1;
  logic [DW-1:0] mem8 [16];
  logic [DW-1:0] mem7 [16];

  logic r8_rdy, r8_ena, r8_wea, r8_enb, r8_web, r8_busy, r8_done;
  logic [AW-1:0] r8_aa, r8_ab;
  logic [DW-1:0] r8_da, r8_db;
  logic [31:0] r8_cyc;
  logic r7_rdy, r7_ena, r7_wea, r7_enb, r7_web, r7_busy, r7_done;
  logic [AW-1:0] r7_aa, r7_ab;
  logic [DW-1:0] r7_da, r7_db;
  logic [31:0] r7_cyc;
  logic r1_rdy, r1_ena, r1_wea, r1_enb, r1_web, r1_busy, r1_done;
  logic [AW-1:0] r1_aa, r1_ab;
  logic [DW-1:0] r1_da, r1_db;
  logic [31:0] r1_cyc;

  always #5 clk = ~clk;

`ifndef IN_MAT_LOADER_STATS_EN
  assign r8_cyc = '0;
  assign r7_cyc = '0;
  assign r1_cyc = '0;
`endif

  in_mat_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(r8_rdy), .in_mat_ena(r8_ena), .in_mat_wea(r8_wea), .in_mat_wr_addra(r8_aa),
    .in_mat_dina(r8_da), .in_mat_enb(r8_enb), .in_mat_web(r8_web), .in_mat_wr_addrb(r8_ab),
    .in_mat_dinb(r8_db), .out_busy(r8_busy), .out_done(r8_done)
`ifdef IN_MAT_LOADER_STATS_EN
    , .out_load_cycles(r8_cyc)
`endif
  );

  in_mat_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(7)) u7 (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(r7_rdy), .in_mat_ena(r7_ena), .in_mat_wea(r7_wea), .in_mat_wr_addra(r7_aa),
    .in_mat_dina(r7_da), .in_mat_enb(r7_enb), .in_mat_web(r7_web), .in_mat_wr_addrb(r7_ab),
    .in_mat_dinb(r7_db), .out_busy(r7_busy), .out_done(r7_done)
`ifdef IN_MAT_LOADER_STATS_EN
    , .out_load_cycles(r7_cyc)
`endif
  );

  in_mat_stream_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(r1_rdy), .in_mat_ena(r1_ena), .in_mat_wea(r1_wea), .in_mat_wr_addra(r1_aa),
    .in_mat_dina(r1_da), .in_mat_enb(r1_enb), .in_mat_web(r1_web), .in_mat_wr_addrb(r1_ab),
    .in_mat_dinb(r1_db), .out_busy(r1_busy), .out_done(r1_done)
`ifdef IN_MAT_LOADER_STATS_EN
    , .out_load_cycles(r1_cyc)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next-cycle expectation from the rules: words numbered in acceptance order, odd-numbered
  // words complete a pair, the last word closes the load, completion follows two cycles later.
  function automatic model_t step(input model_t m, input int unsigned n, input logic start,
                                  input logic valid, input logic [DW-1:0] data);
    model_t r = m;
    int unsigned idx;
    r.ena  = 1'b0;
    r.enb  = 1'b0;
    r.done = 1'b0;
    if (m.phase != 0 && m.cycles != 32'hFFFF_FFFF) r.cycles = m.cycles + 1;
    case (m.phase)
      0: if (start) begin
        r.phase = 1; r.cnt = 0; r.ready = 1'b1; r.busy = 1'b1; r.cycles = 0;
      end
      1: if (valid) begin
        idx = m.cnt;
        r.cnt = idx + 1;
        if (idx < 8) r.words[idx] = data;
        if (idx % 2 == 1) begin
          r.ena = 1'b1; r.addra = AW'(idx - 1); r.dina = m.held;
          r.enb = 1'b1; r.addrb = AW'(idx);     r.dinb = data;
        end else begin
          r.held = data;
          if (idx == n - 1) begin
            r.ena = 1'b1; r.addra = AW'(idx); r.dina = data;
          end
        end
        if (idx == n - 1) begin
          r.phase = 2; r.ready = 1'b0;
        end
      end
      2: begin
        r.phase = 3; r.busy = 1'b0; r.done = 1'b1;
      end
      default: r.phase = 0;
    endcase
    return r;
  endfunction

  task automatic compare(input string nm, input model_t m, input logic rdy, input logic ena,
                         input logic wea, input logic enb, input logic web, input logic [AW-1:0] aa,
                         input logic [DW-1:0] da, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         input logic busy, input logic done, input logic [31:0] cyc);
    check_eq({nm, ".s_ready"}, 64'(rdy), 64'(m.ready));
    check_eq({nm, ".ena"}, 64'(ena), 64'(m.ena));
    check_eq({nm, ".wea"}, 64'(wea), 64'(m.ena));
    check_eq({nm, ".enb"}, 64'(enb), 64'(m.enb));
    check_eq({nm, ".web"}, 64'(web), 64'(m.enb));
    check_eq({nm, ".addra"}, 64'(aa), 64'(m.addra));
    check_eq({nm, ".dina"}, 64'(da), 64'(m.dina));
    check_eq({nm, ".addrb"}, 64'(ab), 64'(m.addrb));
    check_eq({nm, ".dinb"}, 64'(db), 64'(m.dinb));
    check_eq({nm, ".busy"}, 64'(busy), 64'(m.busy));
    check_eq({nm, ".done"}, 64'(done), 64'(m.done));
`ifdef IN_MAT_LOADER_STATS_EN
    check_eq({nm, ".cycles"}, 64'(cyc), 64'(m.cycles));
`else
    if (cyc != 32'd0) check_eq({nm, ".cycles_absent"}, 64'(cyc), 64'd0);
`endif
  endtask

  task automatic compare_all();
    compare("n8", m8, r8_rdy, r8_ena, r8_wea, r8_enb, r8_web, r8_aa, r8_da, r8_ab, r8_db,
            r8_busy, r8_done, r8_cyc);
    compare("n7", m7, r7_rdy, r7_ena, r7_wea, r7_enb, r7_web, r7_aa, r7_da, r7_ab, r7_db,
            r7_busy, r7_done, r7_cyc);
    compare("n1", m1, r1_rdy, r1_ena, r1_wea, r1_enb, r1_web, r1_aa, r1_da, r1_ab, r1_db,
            r1_busy, r1_done, r1_cyc);
  endtask

  // One clock: models advance on the edge with the inputs the DUTs saw, outputs checked #1 later.
  task automatic cycle();
    @(posedge clk);
    if (m8.phase == 0 && in_start) for (int i = 0; i < 16; i++) mem8[i] = '1;
    if (m7.phase == 0 && in_start) for (int i = 0; i < 16; i++) mem7[i] = '1;
    m8 = step(m8, 8, in_start, s_valid, s_data);
    m7 = step(m7, 7, in_start, s_valid, s_data);
    m1 = step(m1, 1, in_start, s_valid, s_data);
    #1;
    compare_all();
    if (r8_ena && r8_wea) mem8[r8_aa] = r8_da;
    if (r8_enb && r8_web) mem8[r8_ab] = r8_db;
    if (r7_ena && r7_wea) mem7[r7_aa] = r7_da;
    if (r7_enb && r7_web) mem7[r7_ab] = r7_db;
    if (m8.done) for (int i = 0; i < 8; i++) check_eq("mem8", 64'(mem8[i]), 64'(m8.words[i]));
    if (m7.done) begin
      for (int i = 0; i < 7; i++) check_eq("mem7", 64'(mem7[i]), 64'(m7.words[i]));
      check_eq("mem7_no_dup", 64'(mem7[7]), 64'(DW'('1)));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    m8 = '0; m7 = '0; m1 = '0;
    compare_all();
    #20;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_start = 1'b0; s_valid = 1'b0; s_data = '0;
    m8 = '0; m7 = '0; m1 = '0;
    for (int i = 0; i < 16; i++) begin mem8[i] = '1; mem7[i] = '1; end
    #1;
    compare_all();
    #20;
    rst_n = 1'b1;
    cycle();

    // Continuous stream, data = index.
    in_start = 1'b1;
    cycle();
    in_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = DW'(i);
      cycle();
    end
    s_valid = 1'b0;
`ifdef IN_MAT_LOADER_STATS_EN
    check_eq("stats_continuous8", 64'(r8_cyc), 64'd10);
`endif
    cycle();

    // Valid while idle must not be consumed; then a gapped load with restart attempts mid-load.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom);
      cycle();
    end
    in_start = 1'b1; s_valid = 1'b0;
    cycle();
    for (int i = 0; i < 40; i++) begin
      in_start = (i == 5 || i == 12);
      s_valid  = ($urandom_range(0, 99) < 60);
      s_data   = DW'($urandom);
      cycle();
    end
    in_start = 1'b0; s_valid = 1'b0;
    cycle();

    // Asynchronous reset after four accepted words, then a fresh full load.
    in_start = 1'b1;
    cycle();
    in_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DW'(100 + i);
      cycle();
    end
    s_valid = 1'b0;
    apply_reset();
    cycle();
    in_start = 1'b1;
    cycle();
    in_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = DW'(200 + i);
      cycle();
    end
    s_valid = 1'b0;
    cycle();

    // Free-running random starts, gaps and data.
    for (int i = 0; i < 400; i++) begin
      in_start = ($urandom_range(0, 9) == 0);
      s_valid  = ($urandom_range(0, 99) < 70);
      s_data   = DW'($urandom);
      cycle();
    end
    in_start = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
